// File: rtl/gpu_receiver_sequencer.sv
// Frame sequencer: per batch it loads and sweeps X, WIDTH, Y, HEIGHT, then writes COLOR.
// Outputs are registered and follow start by one cycle; there is no backpressure, and start is ignored while busy.
module gpu_receiver_sequencer #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int BATCH_COUNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [2:0] state,
    output logic [9:0] coord_generator,
    output logic [3:0] rect_counter,
    output logic [1:0] batch_counter,
    output logic       batch_completed,
    output logic [9:0] src_addr,
    output logic       busy,
    output logic       finish
);

    typedef enum logic [1:0] {IDLE, LOAD, SWEEP, DRAIN} phase_t;

    localparam logic [2:0] F_X = 3'd1;
    localparam logic [2:0] F_W = 3'd2;
    localparam logic [2:0] F_Y = 3'd3;
    localparam logic [2:0] F_H = 3'd4;
    localparam logic [2:0] F_C = 3'd5;
    localparam logic [1:0] LAST_BATCH = 2'(BATCH_COUNT - 1);
    localparam logic [9:0] H_LAST     = 10'(H_RES - 1);
    localparam logic [9:0] V_LAST     = 10'(V_RES - 1);

    phase_t     phase_q, phase_d;
    logic [2:0] field_q, field_d;
    logic [9:0] cnt_q, cnt_d;
    logic [1:0] batch_q, batch_d;
    logic [9:0] sweep_last;

    logic [2:0] state_q, state_d;
    logic [9:0] coord_q, coord_d;
    logic [3:0] rect_q, rect_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic       bdone_q, bdone_d;
    logic [9:0] src_q, src_d;
    logic       busy_q, busy_d;
    logic       finish_q, finish_d;
    logic [5:0] rect_idx;

    always_comb begin
        sweep_last = 10'd15;
        case (field_q)
            F_X, F_W: sweep_last = H_LAST;
            F_Y, F_H: sweep_last = V_LAST;
            default:  sweep_last = 10'd15;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= IDLE;
            field_q <= 3'd0;
            cnt_q   <= 10'd0;
            batch_q <= 2'd0;
        end else begin
            phase_q <= phase_d;
            field_q <= field_d;
            cnt_q   <= cnt_d;
            batch_q <= batch_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        field_d = field_q;
        cnt_d   = cnt_q;
        batch_d = batch_q;
        case (phase_q)
            IDLE: begin
                if (start) begin
                    phase_d = LOAD;
                    field_d = F_X;
                    cnt_d   = 10'd0;
                    batch_d = 2'd0;
                end
            end
            LOAD: begin
                if (cnt_q == 10'd15) begin
                    phase_d = SWEEP;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            SWEEP: begin
                if (cnt_q == sweep_last) begin
                    cnt_d = 10'd0;
                    if (field_q == F_C) begin
                        if (batch_q == LAST_BATCH) begin
                            phase_d = DRAIN;
                        end else begin
                            batch_d = batch_q + 2'd1;
                            field_d = F_X;
                            phase_d = LOAD;
                        end
                    end else begin
                        field_d = field_q + 3'd1;
                        // COLOR has no load phase; go straight to its write sweep
                        phase_d = (field_q == F_H) ? SWEEP : LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == 10'd2) begin
                    phase_d = IDLE;
                    cnt_d   = 10'd0;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            default: phase_d = IDLE;
        endcase
    end

    // Output tuple is decoded from next state so every port is a flop.
    always_comb begin
        rect_idx = {batch_d, cnt_d[3:0]};
        state_d  = 3'd0;
        coord_d  = 10'd0;
        rect_d   = 4'd0;
        bcnt_d   = 2'd0;
        bdone_d  = 1'b0;
        src_d    = 10'd0;
        busy_d   = 1'b0;
        finish_d = 1'b0;
        case (phase_d)
            LOAD: begin
                state_d = field_d;
                rect_d  = cnt_d[3:0];
                bcnt_d  = batch_d;
                src_d   = 10'(rect_idx) * 10'd5 + 10'(field_d - 3'd1);
                busy_d  = 1'b1;
            end
            SWEEP: begin
                state_d = field_d;
                bcnt_d  = batch_d;
                bdone_d = 1'b1;
                busy_d  = 1'b1;
                if (field_d == F_C) begin
                    coord_d = 10'(rect_idx);
                    src_d   = 10'(rect_idx) * 10'd5 + 10'd4;
                end else begin
                    coord_d = cnt_d;
                end
            end
            DRAIN: begin
                busy_d   = (cnt_d != 10'd2);
                finish_d = (cnt_d == 10'd2);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= 3'd0;
            coord_q  <= 10'd0;
            rect_q   <= 4'd0;
            bcnt_q   <= 2'd0;
            bdone_q  <= 1'b0;
            src_q    <= 10'd0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            coord_q  <= coord_d;
            rect_q   <= rect_d;
            bcnt_q   <= bcnt_d;
            bdone_q  <= bdone_d;
            src_q    <= src_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
        end
    end

    assign state           = state_q;
    assign coord_generator = coord_q;
    assign rect_counter    = rect_q;
    assign batch_counter   = bcnt_q;
    assign batch_completed = bdone_q;
    assign src_addr        = src_q;
    assign busy            = busy_q;
    assign finish          = finish_q;

endmodule

// File: tb/tb_gpu_receiver_sequencer.sv
// Bench for gpu_receiver_sequencer: default-size and tiny instances checked cycle by cycle against a frame model.
module tb_gpu_receiver_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start2;

    logic [2:0] st1, st2;
    logic [9:0] co1, co2, sa1, sa2;
    logic [3:0] rc1, rc2;
    logic [1:0] bt1, bt2;
    logic       bc1, bc2, bz1, bz2, fn1, fn2;

    int         n_chk = 0;
    int         n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    gpu_receiver_sequencer dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .state(st1), .coord_generator(co1), .rect_counter(rc1), .batch_counter(bt1),
        .batch_completed(bc1), .src_addr(sa1), .busy(bz1), .finish(fn1)
    );

    gpu_receiver_sequencer #(.H_RES(8), .V_RES(4), .BATCH_COUNT(1)) dut2 (
        .clk(clk), .reset(reset), .start(start2),
        .state(st2), .coord_generator(co2), .rect_counter(rc2), .batch_counter(bt2),
        .batch_completed(bc2), .src_addr(sa2), .busy(bz2), .finish(fn2)
    );

    wire [31:0] tup1 = {st1, co1, rc1, bt1, bc1, sa1, bz1, fn1};
    wire [31:0] tup2 = {st2, co2, rc2, bt2, bc2, sa2, bz2, fn2};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] pk(int s, int co, int rc, int bt, int bc, int sa, int bz, int fn);
        return {3'(s), 10'(co), 4'(rc), 2'(bt), 1'(bc), 10'(sa), 1'(bz), 1'(fn)};
    endfunction

    // Expected tuple for every cycle from cycle 1 through the finish cycle.
    task automatic build(input int h, input int v, input int nb);
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            for (int f = 1; f <= 5; f++) begin
                if (f < 5) begin
                    for (int r = 0; r < 16; r++)
                        exp_q.push_back(pk(f, 0, r, b, 0, (b*16 + r)*5 + f - 1, 1, 0));
                    for (int i = 0; i < ((f <= 2) ? h : v); i++)
                        exp_q.push_back(pk(f, i, 0, b, 1, 0, 1, 0));
                end else begin
                    for (int i = 0; i < 16; i++)
                        exp_q.push_back(pk(5, b*16 + i, 0, b, 1, (b*16 + i)*5 + 4, 1, 0));
                end
            end
        end
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(pk(0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    // Entered and left at #1 after a rising edge. Start is re-asserted in the finish cycle.
    task automatic run_frame(input string tag, input int which, input int noise, input int fin_exp);
        int fin_at;
        logic [31:0] t;
        fin_at = -1;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start2 = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            t = (which == 1) ? tup1 : tup2;
            check(tag, t, exp_q[k]);
            if (t[0] && fin_at < 0) fin_at = k + 1;
            if (k == exp_q.size() - 1 || (noise != 0 && $urandom_range(0, 199) == 0)) begin
                if (which == 1) start1 = 1'b1; else start2 = 1'b1;
            end
            @(posedge clk); #1;
            start1 = 1'b0; start2 = 1'b0;
        end
        check({tag, "_fin_cycle"}, 32'(fin_at), 32'(fin_exp));
        check({tag, "_idle_after"}, (which == 1) ? tup1 : tup2, 32'd0);
    endtask

    initial begin
        int n;
        reset  = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_dut1", tup1, 32'd0);
        check("reset_dut2", tup2, 32'd0);
        @(negedge clk) reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_dut1", tup1, 32'd0);

        build(640, 480, 4);
        check("model_len", 32'(exp_q.size()), 32'd9283);
        run_frame("frame_noisy", 1, 1, 9283);

        // Abort mid-frame with a two-cycle reset, then a clean frame must start over.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        n = $urandom_range(2500, 3500);
        repeat (n) @(posedge clk);
        check("pre_abort_busy", 32'(bz1), 32'd1);
        @(negedge clk) reset = 1'b1;
        #1 check("rst_async", tup1, 32'd0);
        @(posedge clk); #1 check("rst_hold1", tup1, 32'd0);
        @(posedge clk); #1 check("rst_hold2", tup1, 32'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1 check("post_rst_idle", tup1, 32'd0);
        run_frame("frame_after_rst", 1, 0, 9283);

        build(8, 4, 1);
        run_frame("frame_small", 2, 1, 107);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gpu_receiver_sequencer.md
GPU_RECEIVER_SEQUENCER -- requirements
Module: gpu_receiver_sequencer

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning the X/WIDTH sweep length in coordinates.
REQ-002 SHALL have parameter V_RES, default 480, meaning the Y/HEIGHT sweep length in coordinates.
REQ-003 SHALL have parameter BATCH_COUNT, default 4, meaning the number of 16-rect batches per frame.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: single-cycle request to begin a frame sequence.
REQ-007 SHALL have port state, output, 3 bits: field code, 0 idle/drain, 1 X, 2 WIDTH, 3 Y, 4 HEIGHT, 5 COLOR.
REQ-008 SHALL have port coord_generator, output, 10 bits: sweep coordinate or color-write address.
REQ-009 SHALL have port rect_counter, output, 4 bits: rect index within the batch during load.
REQ-010 SHALL have port batch_counter, output, 2 bits: current batch index.
REQ-011 SHALL have port batch_completed, output, 1 bit: 0 = load phase, 1 = sweep/write phase.
REQ-012 SHALL have port src_addr, output, 10 bits: word address into rect source memory.
REQ-013 SHALL have port busy, output, 1 bit: high from start acceptance until finish.
REQ-014 SHALL have port finish, output, 1 bit: one-cycle pulse when the frame sequence has fully retired.

Function
REQ-015 All outputs SHALL be registered; the tuple (state, coord_generator, rect_counter, batch_counter, batch_completed, src_addr) SHALL change together each cycle.
REQ-016 FSM states SHALL be IDLE, LOAD, SWEEP, DRAIN.
REQ-017 IDLE: start=1 SHALL be accepted in cycle 0; the first LOAD tuple SHALL be presented in cycle 1; busy SHALL rise in cycle 1.
REQ-018 start SHALL be ignored while busy=1, including in the finish cycle.
REQ-019 Field order per batch SHALL be X, WIDTH, Y, HEIGHT, COLOR; batches SHALL run 0..BATCH_COUNT-1.
REQ-020 LOAD (fields X..HEIGHT): 16 cycles, batch_completed=0, rect_counter 0..15, coord_generator=0.
REQ-021 SWEEP for X/WIDTH: H_RES cycles with coord_generator 0..H_RES-1; for Y/HEIGHT: V_RES cycles with 0..V_RES-1; batch_completed=1, rect_counter=0.
REQ-022 COLOR SHALL have no LOAD; SWEEP of 16 cycles with coord_generator = batch*16+i, i=0..15, batch_completed=1.
REQ-023 src_addr SHALL equal rect*5+f, f = state-1, rect = batch*16+rect_counter in LOAD and batch*16+i in COLOR SWEEP; 0 in X..HEIGHT SWEEP, IDLE and DRAIN.
REQ-024 The source memory returns din exactly 2 cycles after src_addr; no alignment delay SHALL be added in this block.
REQ-025 Cycles per batch SHALL be 2*(16+H_RES)+2*(16+V_RES)+16 (2320 at defaults).
REQ-026 After the last COLOR SWEEP cycle of the last batch, DRAIN SHALL last 3 cycles with state=0, batch_completed=0; finish SHALL pulse in the third DRAIN cycle, busy SHALL fall in that same cycle, then IDLE.
REQ-027 Counter wrap: coord_generator SHALL return to 0 at each field boundary; batch_counter SHALL not wrap within a frame.
REQ-028 In IDLE all tuple outputs SHALL be 0.
REQ-029 Collision memories SHALL be cleared by their owner before start; this block issues no clear sweep.

Reset
REQ-030 On reset=1, asynchronously: state machine to IDLE, all outputs 0, busy=0, finish=0.
REQ-031 Reset asserted mid-frame SHALL abort the sequence with no finish pulse; the next start SHALL begin again at batch 0, field X.

Verification
REQ-032 start in cycle 0 at defaults -> cycle 1: state=1, batch_completed=0, rect_counter=0, src_addr=0; cycle 16: rect_counter=15, src_addr=75.
REQ-033 Same run -> cycle 17: state=1, batch_completed=1, coord_generator=0; cycle 656: coord_generator=639; cycle 657: state=2, rect_counter=0, src_addr=1.
REQ-034 Same run -> batch 1 COLOR cycle i=3: coord_generator=19, src_addr=19*5+4=99; finish only in cycle 9283, busy low from cycle 9283.
REQ-035 start pulsed at cycle 500 of an active frame -> no effect; frame timing identical to REQ-034.
REQ-036 reset asserted at cycle 3000 for 2 cycles, start after release -> all outputs 0 during reset, no finish, new frame begins with batch_counter=0, state=1.
REQ-037 H_RES=8, V_RES=4, BATCH_COUNT=1 -> finish in cycle 16+8+16+8+16+4+16+4+16+3 = 107.
